// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_CLA  = 4'b0000;
  localparam logic [3:0] OP_COM  = 4'b0001;
  localparam logic [3:0] OP_SHR  = 4'b0010;
  localparam logic [3:0] OP_CSL  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_STA  = 4'b0101;
  localparam logic [3:0] OP_LDA  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SHRN = 4'b1011;
  localparam logic [3:0] OP_ROLN = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_ADC  = 4'b1110;
  localparam logic [3:0] OP_ZERO = 4'b1111;

  localparam int N_B = 3;
  localparam int Z_B = 2;
  localparam int C_B = 1;
  localparam int V_B = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle operation evaluation: result plus N/Z/C/V flags, purely combinational.
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   opCode,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         carryIn,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  logic [W:0] sum_s;
  logic       carry_s;
  logic       ovf_s;

  // Opcode decode and flag derivation
  always_comb begin
    result  = {W{1'b0}};
    sum_s   = {(W+1){1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (opCode)
      OP_CLA: result = {W{1'b0}};
      OP_COM: result = ~in1;
      OP_SHR: begin
        result  = {in1[W-1], in1[W-1:1]};
        carry_s = in1[0];
      end
      OP_CSL: begin
        result  = {in1[W-2:0], in1[W-1]};
        carry_s = in1[W-1];
      end
      OP_ADD, OP_ADC: begin
        sum_s   = {1'b0, in1} + {1'b0, in2} + {{W{1'b0}}, (opCode == OP_ADC) ? carryIn : 1'b0};
        result  = sum_s[W-1:0];
        carry_s = sum_s[W];
        ovf_s   = (in1[W-1] == in2[W-1]) && (sum_s[W-1] != in1[W-1]);
      end
      OP_SUB: begin
        sum_s   = {1'b0, in1} + {1'b0, ~in2} + {{W{1'b0}}, 1'b1};
        result  = sum_s[W-1:0];
        carry_s = sum_s[W];
        ovf_s   = (in1[W-1] != in2[W-1]) && (sum_s[W-1] != in1[W-1]);
      end
      OP_STA: result = in1;
      OP_LDA: result = in2;
      OP_AND: result = in1 & in2;
      OP_OR:  result = in1 | in2;
      OP_XOR: result = in1 ^ in2;
      default: result = {W{1'b0}};
    endcase
    flags      = 4'b0000;
    flags[N_B] = result[W-1];
    flags[Z_B] = (result == {W{1'b0}});
    flags[C_B] = carry_s;
    flags[V_B] = ovf_s;
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake; single-cycle ops finish at acceptance,
// SHRN/ROLN/MUL iterate one bit per cycle in RUN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iSTART,
  input  logic [3:0]   iOP,
  input  logic [W-1:0] iIN1,
  input  logic [W-1:0] iIN2,
  output logic [W-1:0] oZ,
  output logic [3:0]   oFLAGS,
  output logic         oBUSY,
  output logic         oDONE
);

  localparam int CW = $clog2(W + 1);

  state_t         state_r, nextState_s;
  logic [CW-1:0]  cnt_r;
  logic [3:0]     op_r;
  logic [W-1:0]   acc_r, mplier_r, mcand_r;
  logic           carry_r;

  logic           accept_s, finish_s, isMulti_s;
  logic [W-1:0]   combRes_s;
  logic [3:0]     combFlags_s;
  logic [W:0]     mulSum_s;
  logic [W-1:0]   stepAcc_s, stepMplier_s;
  logic           stepCarry_s;
  logic [W-1:0]   runRes_s;
  logic [3:0]     runFlags_s;

  alu_comb_unit #(.W(W)) uComb (
    .opCode  (iOP),
    .in1     (iIN1),
    .in2     (iIN2),
    .carryIn (oFLAGS[C_B]),
    .result  (combRes_s),
    .flags   (combFlags_s)
  );

  // Next-state logic and acceptance/finish strobes
  always_comb begin
    nextState_s = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    isMulti_s   = (iOP == OP_SHRN) || (iOP == OP_ROLN) || (iOP == OP_MUL);
    case (state_r)
      IDLE: begin
        if (iSTART) begin
          accept_s    = 1'b1;
          nextState_s = isMulti_s ? RUN : IDLE;
        end else begin
          nextState_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == {CW{1'b0}}) begin
          finish_s    = 1'b1;
          nextState_s = IDLE;
        end else begin
          nextState_s = RUN;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // One bit-step of the iterative datapath; MUL keeps {acc_r, mplier_r} as the product
  always_comb begin
    mulSum_s     = {(W+1){1'b0}};
    stepAcc_s    = acc_r;
    stepMplier_s = mplier_r;
    stepCarry_s  = carry_r;
    case (op_r)
      OP_SHRN: begin
        stepAcc_s   = {acc_r[W-1], acc_r[W-1:1]};
        stepCarry_s = acc_r[0];
      end
      OP_ROLN: begin
        stepAcc_s   = {acc_r[W-2:0], acc_r[W-1]};
        stepCarry_s = acc_r[W-1];
      end
      OP_MUL: begin
        mulSum_s     = {1'b0, acc_r} + (mplier_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
        stepAcc_s    = mulSum_s[W:1];
        stepMplier_s = {mulSum_s[0], mplier_r[W-1:1]};
      end
      default: stepAcc_s = acc_r;
    endcase
  end

  // Final result and flags of a multi-cycle op
  always_comb begin
    runFlags_s = 4'b0000;
    if (op_r == OP_MUL) begin
      runRes_s         = mplier_r;
      runFlags_s[C_B]  = (acc_r != {W{1'b0}});
    end else begin
      runRes_s         = acc_r;
      runFlags_s[C_B]  = carry_r;
    end
    runFlags_s[N_B] = runRes_s[W-1];
    runFlags_s[Z_B] = (runRes_s == {W{1'b0}});
  end

  // Operand latch, counter and iterative datapath registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      op_r     <= 4'b0000;
      acc_r    <= {W{1'b0}};
      mplier_r <= {W{1'b0}};
      mcand_r  <= {W{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else if (accept_s) begin
      op_r     <= iOP;
      acc_r    <= (iOP == OP_MUL) ? {W{1'b0}} : iIN1;
      mplier_r <= iIN2;
      mcand_r  <= iIN1;
      carry_r  <= 1'b0;
      cnt_r    <= (iOP == OP_MUL) ? CW'(W) : CW'(iIN2[SHW-1:0]);
    end else if ((state_r == RUN) && !finish_s) begin
      acc_r    <= stepAcc_s;
      mplier_r <= stepMplier_s;
      carry_r  <= stepCarry_s;
      cnt_r    <= cnt_r - CW'(1);
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // Output registers: result/flags only change when an op completes
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oZ     <= {W{1'b0}};
      oFLAGS <= 4'b0000;
      oBUSY  <= 1'b0;
      oDONE  <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      if (accept_s && !isMulti_s) begin
        oZ     <= combRes_s;
        oFLAGS <= combFlags_s;
        oDONE  <= 1'b1;
        oBUSY  <= 1'b0;
      end else if (accept_s) begin
        oBUSY  <= 1'b1;
      end else if (finish_s) begin
        oZ     <= runRes_s;
        oFLAGS <= runFlags_s;
        oDONE  <= 1'b1;
        oBUSY  <= 1'b0;
      end else begin
        oBUSY  <= oBUSY;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (W=8) against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iSTART = 1'b0;
  logic [3:0] iOP = 4'h0;
  logic [7:0] iIN1 = 8'h00, iIN2 = 8'h00;
  logic [7:0] oZ;
  logic [3:0] oFLAGS;
  logic       oBUSY, oDONE;

  int nChecks = 0;
  int nFails  = 0;
  logic [7:0] expZ = 8'h00;
  logic [3:0] expF = 4'h0;

  alu_seq #(.W(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iOP(iOP),
    .iIN1(iIN1), .iIN2(iIN2), .oZ(oZ), .oFLAGS(oFLAGS),
    .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int toSigned(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Returns {N,Z,C,V, result} computed from plain integer arithmetic.
  function automatic logic [11:0] refModel(input logic [3:0] op, input logic [7:0] a8,
                                           input logic [7:0] b8, input logic cin);
    int a, b, r, s, sv, k, c, v;
    logic [31:0] rv;
    a = int'(a8); b = int'(b8); r = 0; c = 0; v = 0; k = b % 8;
    case (op)
      4'd1:  r = 255 - a;
      4'd2:  begin r = (a / 2) + (a >= 128 ? 128 : 0); c = a % 2; end
      4'd3:  begin r = ((a * 2) % 256) + (a >= 128 ? 1 : 0); c = (a >= 128) ? 1 : 0; end
      4'd4, 4'd14: begin
        s = a + b + ((op == 4'd14) ? int'(cin) : 0);
        sv = toSigned(a) + toSigned(b) + ((op == 4'd14) ? int'(cin) : 0);
        r = s % 256; c = (s > 255) ? 1 : 0; v = (sv > 127 || sv < -128) ? 1 : 0;
      end
      4'd5:  r = a;
      4'd6:  r = b;
      4'd7:  begin
        s = a + (255 - b) + 1; sv = toSigned(a) - toSigned(b);
        r = s % 256; c = (s > 255) ? 1 : 0; v = (sv > 127 || sv < -128) ? 1 : 0;
      end
      4'd8:  r = int'(a8 & b8);
      4'd9:  r = int'(a8 | b8);
      4'd10: r = int'(a8 ^ b8);
      4'd11: begin
        r = (toSigned(a) >>> k) & 255;
        c = (k == 0) ? 0 : (a >> (k - 1)) & 1;
      end
      4'd12: begin
        r = ((a << k) | (a >> (8 - k))) & 255;
        c = (k == 0) ? 0 : r & 1;
      end
      4'd13: begin s = a * b; r = s % 256; c = (s >= 256) ? 1 : 0; end
      default: r = 0;
    endcase
    rv = 32'(r);
    return {rv[7], (r == 0), c[0], v[0], rv[7:0]};
  endfunction

  task automatic doOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input bit poke);
    logic [11:0] e;
    int k, n;
    bit multi, done;
    e = refModel(op, a, b, expF[1]);
    multi = (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
    k = (op == 4'd13) ? 8 : int'(b[2:0]);
    iSTART = 1'b1; iOP = op; iIN1 = a; iIN2 = b;
    @(posedge iCLK); #1;
    iSTART = 1'b0; iOP = 4'($urandom); iIN1 = 8'($urandom); iIN2 = 8'($urandom);
    if (!multi) begin
      checkVal("done_single", 32'(oDONE), 32'd1);
      checkVal("busy_single", 32'(oBUSY), 32'd0);
    end else begin
      checkVal("busy_t0", 32'(oBUSY), 32'd1);
      checkVal("done_t0", 32'(oDONE), 32'd0);
      if (poke) begin iSTART = 1'b1; iOP = OP_LDA; iIN2 = 8'h55; end
      n = 1; done = 0;
      while (!done && n <= 20) begin
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        if (oDONE) done = 1;
        else begin
          checkVal("busy_run", 32'(oBUSY), 32'd1);
          checkVal("hold_z", 32'(oZ), 32'(expZ));
          n++;
        end
      end
      checkVal("latency", 32'(n), 32'(k + 1));
      checkVal("busy_end", 32'(oBUSY), 32'd0);
    end
    checkVal($sformatf("z_op%0d", op), 32'(oZ), 32'(e[7:0]));
    checkVal($sformatf("flags_op%0d", op), 32'(oFLAGS), 32'(e[11:8]));
    expZ = e[7:0]; expF = e[11:8];
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge iCLK); #1;
      checkVal("done_idle", 32'(oDONE), 32'd0);
    end
  endtask

  initial begin
    iRST = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    checkVal("rst_z", 32'(oZ), 32'd0);
    checkVal("rst_flags", 32'(oFLAGS), 32'd0);
    checkVal("rst_busy", 32'(oBUSY), 32'd0);
    checkVal("rst_done", 32'(oDONE), 32'd0);
    iRST = 1'b0;

    doOp(OP_ADD, 8'h7F, 8'h01, 1'b0);
    checkVal("add_ovf_flags", 32'(oFLAGS), 32'h9);
    idle(1);
    doOp(OP_ADD, 8'hFF, 8'h01, 1'b0);
    doOp(OP_ADC, 8'h00, 8'h00, 1'b0);
    checkVal("adc_z", 32'(oZ), 32'h01);
    doOp(OP_SUB, 8'h05, 8'h07, 1'b0);
    checkVal("sub_z", 32'(oZ), 32'hFE);
    doOp(OP_SHRN, 8'h80, 8'h03, 1'b1);
    checkVal("shrn_z", 32'(oZ), 32'hF0);
    idle(1);
    checkVal("poke_ignored", 32'(oZ), 32'hF0);
    doOp(OP_ROLN, 8'h81, 8'h00, 1'b0);
    checkVal("roln0_z", 32'(oZ), 32'h81);
    doOp(OP_MUL, 8'h0D, 8'h0B, 1'b0);
    checkVal("mul_z", 32'(oZ), 32'h8F);
    doOp(OP_MUL, 8'h10, 8'h10, 1'b0);
    checkVal("mul_flags", 32'(oFLAGS), 32'h6);

    // Reset in the middle of a multiply
    iSTART = 1'b1; iOP = OP_MUL; iIN1 = 8'hFF; iIN2 = 8'hFF;
    @(posedge iCLK); #1; iSTART = 1'b0;
    repeat (3) @(posedge iCLK);
    #1; iRST = 1'b1;
    @(posedge iCLK); #1; iRST = 1'b0;
    checkVal("mrst_z", 32'(oZ), 32'd0);
    checkVal("mrst_flags", 32'(oFLAGS), 32'd0);
    checkVal("mrst_busy", 32'(oBUSY), 32'd0);
    checkVal("mrst_done", 32'(oDONE), 32'd0);
    expZ = 8'h00; expF = 4'h0;
    doOp(OP_ADD, 8'h12, 8'h34, 1'b0);
    idle(10);

    doOp(OP_CLA, 8'hB4, 8'h3C, 1'b0);
    doOp(OP_COM, 8'hB4, 8'h3C, 1'b0);
    checkVal("com_z", 32'(oZ), 32'h4B);
    doOp(OP_SHR, 8'hB4, 8'h3C, 1'b0);
    checkVal("shr_z", 32'(oZ), 32'hDA);
    doOp(OP_CSL, 8'hB4, 8'h3C, 1'b0);
    checkVal("csl_z", 32'(oZ), 32'h69);
    checkVal("csl_c", 32'(oFLAGS[C_B]), 32'd1);
    doOp(OP_STA, 8'hB4, 8'h3C, 1'b0);
    doOp(OP_LDA, 8'hB4, 8'h3C, 1'b0);

    for (int i = 0; i < 300; i++) begin
      doOp(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the CPU's 8-bit combinational ALU.
- Keeps opcodes 0000–0110 with their existing encodings and meanings, at width W.
- Adds subtract, logic ops, add-with-carry, a status-flag register, and iterative multi-cycle ops (multi-bit shift/rotate, shift-add multiply).
- Sits between the control unit and the accumulator datapath, using a start/busy/done handshake.

Parameters:
- W, 8, operand/result width; must be >= 2.
- SHW, $clog2(W), width of the shift-amount field taken from iIN2[SHW-1:0].

Ports:
- iCLK  input  1  clock; all state updates on the rising edge.
- iRST  input  1  synchronous, active-high reset.
- iSTART  input  1  request strobe; sampled only while idle.
- iOP  input  4  opcode, sampled with iSTART.
- iIN1  input  W  operand 1 (accumulator side).
- iIN2  input  W  operand 2 (memory side); low SHW bits give the shift count for SHRN/ROLN.
- oZ  output  W  registered result.
- oFLAGS  output  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- oBUSY  output  1  high while a multi-cycle op is running.
- oDONE  output  1  one-cycle pulse when oZ/oFLAGS have just been updated.

Behaviour:
- Reset: oZ=0, oFLAGS=0, oBUSY=0, oDONE=0, state=IDLE. Reset overrides everything, aborts any op in progress, and discards its result.
- States: IDLE, RUN.
- iSTART is honoured only in IDLE. iSTART while oBUSY=1 is ignored, not queued. iIN1/iIN2/iOP are latched at acceptance, so they may change afterwards.
- Single-cycle ops, accepted at edge T0:
  - oZ/oFLAGS are written at T0.
  - oDONE=1 for the cycle after T0.
  - oBUSY stays 0.
  - Back-to-back starts every cycle are allowed.
- Opcodes:
  - 0000 CLA: result 0.
  - 0001 COM: ~IN1.
  - 0010 SHR: arithmetic right shift by 1; C = IN1[0].
  - 0011 CSL: rotate left by 1; C = IN1[W-1].
  - 0100 ADD: IN1+IN2; C = carry out.
  - 0101 STA: IN1.
  - 0110 LDA: IN2.
  - 0111 SUB: IN1+~IN2+1; C = carry out (1 = no borrow).
  - 1000 AND, 1001 OR, 1010 XOR.
  - 1110 ADC: IN1+IN2+C, using the flag C held at acceptance.
  - 1111: result 0 (as CLA).
- V for ADD/ADC/SUB is two's-complement overflow.
- Multi-cycle ops (state RUN):
  - 1011 SHRN: arithmetic right shift by k = IN2[SHW-1:0].
  - 1100 ROLN: rotate left by k = IN2[SHW-1:0].
  - 1101 MUL: unsigned shift-add multiply, k = W.
  - At accept (T0): operands are latched, cnt=k, state=RUN, oBUSY=1 from the cycle after T0.
  - Each RUN edge with cnt!=0: perform one bit-step, cnt--.
  - RUN edge with cnt==0: write oZ/oFLAGS, pulse oDONE, return to IDLE (oBUSY=0).
  - Latency: result lands k+1 edges after T0. The busy window is k+1 cycles. k=0 still takes 1 RUN cycle.
  - oZ/oFLAGS hold their previous values while RUN.
- Flag rules:
  - N = result[W-1] and Z = (result==0), for every op.
  - C and V are 0 unless stated above, except the following.
  - SHRN/ROLN: C = last bit shifted or rotated out (0 if k=0).
  - MUL: oZ = low W bits of the product; C = 1 if the high W bits are nonzero; V = 0.
- Unlisted widths: arithmetic is modulo 2^W; no saturation.

Decomposition:
- Package alu_pkg:
  - localparams for the 16 opcodes;
  - flag bit indices N_B=3, Z_B=2, C_B=1, V_B=0;
  - state encodings IDLE/RUN.
- Sub-module alu_comb_unit (parametrised W): pure combinational single-cycle op evaluation, returning result and flags.
- alu_seq holds the FSM, the counter, the shift/multiply datapath (accumulator, multiplicand, multiplier registers), and the output registers.

Test Plan (W=8):
- ADD 8'h7F+8'h01 -> next cycle oZ=8'h80, oFLAGS N=1 Z=0 C=0 V=1, oDONE single pulse, oBUSY never high.
- ADD 8'hFF+8'h01 (oZ=00, C=1, Z=1), then ADC 8'h00+8'h00 -> oZ=8'h01, C=0; then SUB 8'h05-8'h07 -> oZ=8'hFE, N=1, C=0.
- SHRN IN1=8'h80, IN2=8'h03 -> oBUSY high 4 cycles, oZ=8'hF0, C=0, N=1. A second iSTART (LDA 8'h55) during busy is ignored and oZ remains 8'hF0. ROLN 8'h81 by 0 -> oZ=8'h81 after 1 RUN cycle, C=0.
- MUL 8'h0D*8'h0B -> 9 edges after accept oZ=8'h8F, C=0, N=1. MUL 8'h10*8'h10 -> oZ=8'h00, Z=1, C=1.
- Assert iRST for 1 cycle in the middle of a MUL -> next cycle oZ=0, oFLAGS=0, oBUSY=0, no oDONE. A new ADD is accepted immediately afterwards and completes normally.
- Legacy ops CLA/COM/SHR/CSL/STA/LDA with IN1=8'hB4, IN2=8'h3C -> oZ = 00/4B/DA/69/B4/3C respectively. Flags: CSL C=1, SHR C=0.
